// File: rtl/r2w1_write_arbiter_pkg.sv
// Shared definitions for the 2R/1W register-file write arbiter.
//   state_t     : controller state encoding (ST_INIT sweeps the RAM, ST_RUN arbitrates)
//   GRANT_ID_W  : width of the encoded requester index (covers up to 8 requesters)
package r2w1_write_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int GRANT_ID_W = 3;

endpackage

// File: rtl/r2w1_write_arbiter_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters, purely combinational.
// Ports:
//   req        in   NUM_REQ     request vector
//   ptr        in   GRANT_ID_W  highest-priority index this cycle (always < NUM_REQ)
//   grant      out  NUM_REQ     one-hot-or-zero grant
//   grant_idx  out  GRANT_ID_W  encoded index of the granted requester
//   any_req    out  1           at least one request is present
module r2w1_write_arbiter_rr_arbiter
    import r2w1_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]    req,
    input  logic [GRANT_ID_W-1:0] ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [GRANT_ID_W-1:0] grant_idx,
    output logic                  any_req
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int          idx;
    logic [IW-1:0] sel;

    // Scan upward from ptr with wrap; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IW'(idx);
            if (!any_req && req[sel]) begin
                any_req    = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = GRANT_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/r2w1_write_arbiter.sv
// Owns the write port of a 2-read/1-write register-file RAM. After reset it
// writes INIT_VALUE to every address, then grants at most one requester per
// cycle with round-robin fairness.
// Ports:
//   clk          in   1                    system clock
//   reset_n      in   1                    synchronous active-low reset
//   req_valid    in   NUM_REQ              per-requester write request
//   req_addr     in   NUM_REQ*ADDR_WIDTH   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data     in   NUM_REQ*DATA_WIDTH   packed data, same packing
//   req_ready    out  NUM_REQ              one-hot-or-zero grant (combinational)
//   ram_addr_w   out  ADDR_WIDTH           RAM write address (registered)
//   ram_data_in  out  DATA_WIDTH           RAM write data (registered)
//   ram_we       out  1                    RAM write enable (registered)
//   init_done    out  1                    init sweep finished
//   grant_id     out  3                    requester written last cycle
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping addresses 0..depth-1 with INIT_VALUE, no grants
// ST_RUN  | round-robin arbitration, one write per cycle
module r2w1_write_arbiter
    import r2w1_write_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    NUM_REQ    = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ADDR_WIDTH-1:0]          ram_addr_w,
    output logic [DATA_WIDTH-1:0]          ram_data_in,
    output logic                           ram_we,
    output logic                           init_done,
    output logic [GRANT_ID_W-1:0]          grant_id
);

    // One extra bit so the counter can record "last address issued" without
    // wrapping back to 0 and starting a second pass.
    localparam int CNT_W = ADDR_WIDTH + 1;

    state_t                  state;
    logic [CNT_W-1:0]        init_cnt;
    logic [GRANT_ID_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [GRANT_ID_W-1:0]   arb_idx;
    logic                    arb_any;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    r2w1_write_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // Grant depends only on req_valid and state, never on addr/data.
    assign req_ready = (state == ST_RUN) ? arb_grant : '0;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            rr_ptr      <= '0;
            ram_we      <= 1'b0;
            ram_addr_w  <= '0;
            ram_data_in <= '0;
            init_done   <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!init_cnt[ADDR_WIDTH]) begin
                        ram_we      <= 1'b1;
                        ram_addr_w  <= init_cnt[ADDR_WIDTH-1:0];
                        ram_data_in <= INIT_VALUE;
                        init_cnt    <= init_cnt + 1'b1;
                    end else begin
                        ram_we    <= 1'b0;
                        init_done <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (arb_any) begin
                        ram_we      <= 1'b1;
                        ram_addr_w  <= sel_addr;
                        ram_data_in <= sel_data;
                        grant_id    <= arb_idx;
                        if (arb_idx == GRANT_ID_W'(NUM_REQ - 1))
                            rr_ptr <= '0;
                        else
                            rr_ptr <= arb_idx + 1'b1;
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r2w1_write_arbiter.sv
// Self-checking bench for r2w1_write_arbiter (3 requesters, 16-word RAM).
module tb_r2w1_write_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NR    = 3;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INITV = 8'hA5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [AW-1:0]     ram_addr_w;
    logic [DW-1:0]     ram_data_in;
    logic              ram_we;
    logic              init_done;
    logic [2:0]        grant_id;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int            m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_we;
    int            m_gid;
    logic [DW-1:0] ref_mem [DEPTH];

    // RAM driven by the DUT write port
    logic [DW-1:0] ram_arr [DEPTH];

    r2w1_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .INIT_VALUE (INITV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ram_addr_w  (ram_addr_w),
        .ram_data_in (ram_data_in),
        .ram_we      (ram_we),
        .init_done   (init_done),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_arr[ram_addr_w] <= ram_data_in;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reset then sweep; abort_at >= 0 returns right after that sweep address is seen.
    task automatic reset_and_sweep(input int abort_at);
        reset_n   = 1'b0;
        req_valid = '1;
        req_addr  = 12'h321;
        req_data  = 24'h334455;
        @(posedge clk); #1;
        check_val("rst_we",    ram_we, 0);
        check_val("rst_addr",  ram_addr_w, 0);
        check_val("rst_data",  ram_data_in, 0);
        check_val("rst_done",  init_done, 0);
        check_val("rst_gid",   grant_id, 0);
        check_val("rst_ready", req_ready, 0);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            check_val("sweep_we",    ram_we, 1);
            check_val("sweep_addr",  ram_addr_w, i);
            check_val("sweep_data",  ram_data_in, INITV);
            check_val("sweep_done",  init_done, 0);
            check_val("sweep_ready", req_ready, 0);
            if (i == abort_at) return;
        end
        @(posedge clk); #1;
        check_val("post_sweep_we", ram_we, 0);
        check_val("init_done",     init_done, 1);
        m_ptr  = 0;
        m_addr = AW'(DEPTH - 1);
        m_data = INITV;
        m_we   = 1'b0;
        m_gid  = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INITV;
    endtask

    // One RUN cycle: apply requests, check grant, then check the registered write.
    task automatic run_cycle(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                             input logic [NR*DW-1:0] d);
        int g;
        logic [NR-1:0] exp_ready;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
        exp_ready = (g >= 0) ? NR'(1 << g) : '0;
        check_val("req_ready", req_ready, exp_ready);
        if (g >= 0) begin
            m_we   = 1'b1;
            m_addr = a[g*AW +: AW];
            m_data = d[g*DW +: DW];
            m_gid  = g;
            m_ptr  = (g + 1) % NR;
            ref_mem[m_addr] = m_data;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk); #1;
        check_val("ram_we",      ram_we, m_we);
        check_val("ram_addr_w",  ram_addr_w, m_addr);
        check_val("ram_data_in", ram_data_in, m_data);
        if (m_we) check_val("grant_id", grant_id, m_gid);
        check_val("init_done_run", init_done, 1);
    endtask

    initial begin
        logic [NR*AW-1:0] ra;
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rv;
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        @(posedge clk); #1;

        // reset in the middle of the sweep, then a full sweep
        reset_and_sweep(9);
        reset_and_sweep(-1);

        // all three valid, six cycles: grants 0,1,2,0,1,2
        for (int i = 0; i < 6; i++)
            run_cycle(3'b111, {4'(i+8), 4'(i+4), 4'(i)}, {8'(8'h30+i), 8'(8'h20+i), 8'(8'h10+i)});

        // single requester 1: addr 3, data 5C
        run_cycle(3'b010, {4'h0, 4'h3, 4'h0}, {8'h00, 8'h5C, 8'h00});
        run_cycle(3'b000, '0, '0);
        check_val("ram3_read", ram_arr[3], 8'h5C);

        // idle stretch: outputs hold, pointer unchanged (checked by next grant)
        run_cycle(3'b000, 12'hFFF, 24'hFFFFFF);
        run_cycle(3'b000, 12'hABC, 24'h123456);

        // bring pointer back to 0, then 0 and 2 collide on addr 7
        run_cycle(3'b100, {4'hE, 4'h0, 4'h0}, {8'h77, 8'h00, 8'h00});
        run_cycle(3'b101, {4'h7, 4'h0, 4'h7}, {8'h22, 8'h00, 8'h11});
        run_cycle(3'b101, {4'h7, 4'h0, 4'h7}, {8'h22, 8'h00, 8'h11});
        run_cycle(3'b000, '0, '0);
        check_val("ram7_last_wins", ram_arr[7], 8'h22);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rv = NR'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rv = '0;
            ra = 12'($urandom);
            rd = 24'($urandom);
            run_cycle(rv, ra, rd);
        end
        run_cycle(3'b000, '0, '0);
        for (int i = 0; i < DEPTH; i++) check_val("ram_contents", ram_arr[i], ref_mem[i]);

        // reset while in RUN, sweep restarts from 0
        reset_and_sweep(-1);
        for (int i = 0; i < 40; i++) begin
            rv = NR'($urandom_range(0, 7));
            ra = 12'($urandom);
            rd = 24'($urandom);
            run_cycle(rv, ra, rd);
        end
        run_cycle(3'b000, '0, '0);
        for (int i = 0; i < DEPTH; i++) check_val("ram_contents2", ram_arr[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/r2w1_write_arbiter.md
Name: r2w1_write_arbiter

Overview:
- Owns the single write port of a 2-read/1-write register-file RAM and shares it among NUM_REQ requesters (e.g. ALU writeback, load writeback, host/DMA loader).
- After reset, sweeps every RAM address to INIT_VALUE before granting any requester.
- Then grants at most one write per cycle with round-robin fairness.
- Sits between the core's writeback sources and the RAM's addr_w/data_in/we pins; read ports are untouched.

Parameters:
- DATA_WIDTH, 8: RAM word width.
- ADDR_WIDTH, 12: RAM address width; depth = 2**ADDR_WIDTH.
- NUM_REQ, 3: number of write requesters, 2..8.
- INIT_VALUE, 0: word written to every address during the init sweep.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; same packing scheme.
- req_ready  out  NUM_REQ  one-hot-or-zero grant; combinational.
- ram_addr_w  out  ADDR_WIDTH  to RAM addr_w; registered.
- ram_data_in  out  DATA_WIDTH  to RAM data_in; registered.
- ram_we  out  1  to RAM we; registered.
- init_done  out  1  high once the init sweep has completed.
- grant_id  out  3  index of the requester written last cycle; valid when ram_we=1 in RUN.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=INIT, init counter=0, rr pointer=0.
  - ram_we=0, ram_addr_w=0, ram_data_in=0.
  - init_done=0, grant_id=0, req_ready=0.
- Reset mid-sweep or mid-RUN restarts the sweep from address 0. No pending write survives reset.
- State INIT:
  - Each cycle registers ram_we=1, ram_addr_w=counter, ram_data_in=INIT_VALUE; counter increments.
  - When counter = 2**ADDR_WIDTH-1 has been issued, next state is RUN. The counter does not wrap into a second pass.
  - req_ready=0 throughout INIT; requesters must hold valid/addr/data stable.
  - Sweep length is exactly 2**ADDR_WIDTH cycles of ram_we=1.
  - init_done rises in the first RUN cycle, i.e. the cycle after the last sweep write is presented on ram_*. It stays high until reset.
- State RUN:
  - req_ready[i]=1 for exactly one i when any req_valid is set.
  - i is the first valid requester scanning upward from rr pointer, modulo NUM_REQ.
  - Handshake = req_valid[i] & req_ready[i].
  - On handshake, next cycle: ram_we=1, ram_addr_w=req_addr[i], ram_data_in=req_data[i], grant_id=i. Latency is 1 cycle from handshake to RAM write strobe.
  - rr pointer becomes (i+1) mod NUM_REQ on handshake; it is unchanged when idle.
  - No valid request: req_ready=0, and next cycle ram_we=0. ram_addr_w and ram_data_in hold their previous values.
  - Throughput is one write per cycle sustained. Back-to-back grants to the same requester occur only when it is the sole valid requester.
  - Simultaneous requests to the same address from different requesters are serialized in grant order; the later write wins in RAM.
- req_ready must not depend on req_addr or req_data, so there is no combinational loop through requesters.
- Read-after-write visibility follows RAM semantics. This block does no forwarding.

Decomposition:
- Shared package/header: state encodings (ST_INIT=0, ST_RUN=1) and the grant_id width constant.
- One natural sub-module: rr_arbiter (NUM_REQ request vector and pointer in; one-hot grant and encoded index out; purely combinational). The FSM, init counter and output registers stay in the top module.

Test Plan:
- Reset release with ADDR_WIDTH=4, INIT_VALUE=8'hA5:
  - ram_we=1 for exactly 16 consecutive cycles with addresses 0..15 and data A5.
  - init_done rises in the following cycle.
  - req_ready stays 0 throughout the sweep even with all req_valid=1.
- Single requester after init, req 1 writes addr 3 / data 8'h5C:
  - req_ready=3'b010 in the same cycle.
  - Next cycle ram_we=1, ram_addr_w=3, ram_data_in=5C, grant_id=1.
  - A read of addr 3 via the RAM returns 5C.
- All three requesters valid for 6 cycles, pointer starting at 0:
  - Grant order is 0,1,2,0,1,2.
  - ram_we is held high for 6 consecutive cycles.
- Requesters 0 and 2 both write addr 7, with data 11 and 22 respectively, pointer=0:
  - Grants go 0 then 2.
  - Final RAM[7]=22.
- Assert reset_n=0 for one cycle while in RUN or at sweep address 9:
  - Outputs return to reset values.
  - The sweep restarts at address 0 and init_done drops to 0.
- Idle cycles (req_valid=0) between writes:
  - ram_we=0 and ram_addr_w/ram_data_in hold their last values.
  - The rr pointer is unchanged.
